hdmi_qsys_pio_in: RTL and testbench

// Avalon-MM slave input PIO: the read side of the memory-mapped PIO pair. Samples

---
 rtl/hdmi_qsys_pio_in.sv | 120 ++++++++++++
 tb/tb_hdmi_qsys_pio_in.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_qsys_pio_in.sv
// Avalon-MM input PIO: synchronises and debounces external inputs, captures
// selected edges into a W1C register and raises a maskable level interrupt.
module hdmi_qsys_pio_in #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rise_c, fall_c, sel_c, clr_c;
  logic             wr_c;
  logic             wdata_unused;

  // Bits of writedata above WIDTH are intentionally dropped.
  assign wdata_unused = ^writedata;

  // Synchroniser, debounced level, edge history and software registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb stable_d = sync2_q;
    end else begin : g_debounce
      localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q [WIDTH];
      logic [CNT_W-1:0] cnt_d [WIDTH];

      // A bit must disagree with its accepted level for DEBOUNCE_CYCLES
      // consecutive cycles; any agreement restarts the count.
      always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i] = '0;
          if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              stable_d[i] = sync2_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // Edge selection, W1C clear (capture wins) and mask load.
  always_comb begin
    rise_c = stable_q & ~prev_q;
    fall_c = ~stable_q & prev_q;
    if (EDGE_TYPE == 0) begin
      sel_c = rise_c;
    end else if (EDGE_TYPE == 1) begin
      sel_c = fall_c;
    end else begin
      sel_c = rise_c | fall_c;
    end
    wr_c   = chipselect & ~write_n;
    clr_c  = (wr_c && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    edge_d = (edge_q & ~clr_c) | sel_c;
    mask_d = (wr_c && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
  end

  // Zero-wait-state read mux; address 1 and unused upper bits read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(stable_q);
      ADDR_MASK: readdata = 32'(mask_q);
      ADDR_EDGE: readdata = 32'(edge_q);
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_hdmi_qsys_pio_in.sv
// Bench for hdmi_qsys_pio_in: rising/falling/any-edge instances checked by
// directed scenarios and a randomized run against a sliding-window model.
module tb_hdmi_qsys_pio_in;

  localparam int unsigned W = 5;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_r, rd_a, rd_f;
  logic          irq_r, irq_a, irq_f;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hdmi_qsys_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r));

  hdmi_qsys_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  hdmi_qsys_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f));

  // Reference model: an input is accepted once the last D synchronised
  // samples all disagree with the accepted level.
  logic [W-1:0] m_p1, m_p2;
  logic [W-1:0] m_win [D];
  logic [W-1:0] m_win_n [D];
  logic [W-1:0] m_all_hi, m_all_lo;
  logic [W-1:0] m_stable, m_stable_n, m_prev, m_mask, m_mask_n;
  logic [W-1:0] m_edge_r, m_edge_a, m_edge_f, m_clr, m_up, m_down;
  logic         m_wr;

  always_comb begin
    m_win_n[0] = m_p2;
    for (int j = 1; j < D; j++) m_win_n[j] = m_win[j-1];
    m_all_hi = '1;
    m_all_lo = '1;
    for (int j = 0; j < D; j++) begin
      m_all_hi = m_all_hi & m_win_n[j];
      m_all_lo = m_all_lo & ~m_win_n[j];
    end
    m_stable_n = (m_stable & ~m_all_lo) | m_all_hi;
    m_up       = m_stable & ~m_prev;
    m_down     = ~m_stable & m_prev;
    m_wr       = chipselect && !write_n;
    m_clr      = (m_wr && address == 2'd3) ? writedata[W-1:0] : '0;
    m_mask_n   = (m_wr && address == 2'd2) ? writedata[W-1:0] : m_mask;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_p1 <= '0; m_p2 <= '0;
      for (int j = 0; j < D; j++) m_win[j] <= '0;
      m_stable <= '0; m_prev <= '0; m_mask <= '0;
      m_edge_r <= '0; m_edge_a <= '0; m_edge_f <= '0;
    end else begin
      m_p1     <= in_port;
      m_p2     <= m_p1;
      m_win    <= m_win_n;
      m_stable <= m_stable_n;
      m_prev   <= m_stable;
      m_mask   <= m_mask_n;
      m_edge_r <= (m_edge_r & ~m_clr) | m_up;
      m_edge_a <= (m_edge_a & ~m_clr) | m_up | m_down;
      m_edge_f <= (m_edge_f & ~m_clr) | m_down;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic [W-1:0] e);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(e);
      default: return 32'h0;
    endcase
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic test_reset();
    logic [1:0] addrs [3];
    addrs[0] = 2'd0; addrs[1] = 2'd2; addrs[2] = 2'd3;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      in_port = W'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        address = addrs[k]; #1;
        n_tests++;
        if (rd_r !== 32'h0 || rd_a !== 32'h0 || rd_f !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_read addr=%0d got r=%h a=%h f=%h exp=0", addrs[k], rd_r, rd_a, rd_f);
        end
      end
      n_tests++;
      if (irq_r !== 1'b0 || irq_a !== 1'b0 || irq_f !== 1'b0) begin
        n_fail++; $display("FAIL reset_irq got %b%b%b exp 000", irq_r, irq_a, irq_f);
      end
    end
    in_port = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    address = 2'd0; #1;
    n_tests++;
    if (rd_r !== 32'h0) begin n_fail++; $display("FAIL reset_stable got=%h exp=0", rd_r); end
    address = 2'd3; #1;
    n_tests++;
    if (rd_a !== 32'h0) begin n_fail++; $display("FAIL reset_no_edge got=%h exp=0", rd_a); end
  endtask

  task automatic test_rise_latency();
    logic [31:0] exp;
    in_port = 5'b00001;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      address = 2'd0; #1;
      exp = (i >= 6) ? 32'h1 : 32'h0;
      n_tests++;
      if (rd_r !== exp) begin n_fail++; $display("FAIL data_latency cyc=%0d got=%h exp=%h", i, rd_r, exp); end
      address = 2'd3; #1;
      exp = (i >= 7) ? 32'h1 : 32'h0;
      n_tests++;
      if (rd_r !== exp || rd_a !== exp || rd_f !== 32'h0) begin
        n_fail++; $display("FAIL edge_latency cyc=%0d got r=%h a=%h f=%h exp=%h", i, rd_r, rd_a, rd_f, exp);
      end
    end
    n_tests++;
    if (irq_r !== 1'b0) begin n_fail++; $display("FAIL irq_unmasked got=%b exp=0", irq_r); end
    wr(2'd2, 32'h1); #1;
    n_tests++;
    if (irq_r !== 1'b1 || irq_a !== 1'b1 || irq_f !== 1'b0) begin
      n_fail++; $display("FAIL irq_masked got %b%b%b exp 110", irq_r, irq_a, irq_f);
    end
    wr(2'd3, 32'h1);
    address = 2'd3; #1;
    n_tests++;
    if (rd_r !== 32'h0 || irq_r !== 1'b0) begin
      n_fail++; $display("FAIL w1c_clear got edge=%h irq=%b exp 0/0", rd_r, irq_r);
    end
  endtask

  task automatic test_glitch(input int hold);
    logic seen;
    logic [31:0] exp;
    seen = 1'b0;
    in_port = 5'b00101;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == hold - 1) in_port = 5'b00001;
      address = 2'd0; #1;
      seen = seen | rd_r[2];
      exp = exp_rd(2'd0, m_edge_r);
      n_tests++;
      if (rd_r !== exp) begin n_fail++; $display("FAIL glitch_data hold=%0d cyc=%0d got=%h exp=%h", hold, i, rd_r, exp); end
    end
    n_tests++;
    if (seen !== (hold >= 4)) begin
      n_fail++; $display("FAIL glitch_accept hold=%0d got=%b exp=%b", hold, seen, hold >= 4);
    end
    address = 2'd3; #1;
    exp = (hold >= 4) ? 32'h4 : 32'h0;
    n_tests++;
    if (rd_r !== exp || rd_f !== exp) begin
      n_fail++; $display("FAIL glitch_edge hold=%0d got r=%h f=%h exp=%h", hold, rd_r, rd_f, exp);
    end
    wr(2'd3, 32'h1f);
  endtask

  task automatic test_set_wins();
    in_port = 5'b00011;
    for (int i = 1; i <= 6; i++) @(negedge clk);
    address = 2'd0; #1;
    n_tests++;
    if (rd_r !== 32'h3) begin n_fail++; $display("FAIL setwin_pre_data got=%h exp=3", rd_r); end
    address = 2'd3; #1;
    n_tests++;
    if (rd_r !== 32'h0) begin n_fail++; $display("FAIL setwin_pre_edge got=%h exp=0", rd_r); end
    wr(2'd3, 32'h2);
    address = 2'd3; #1;
    n_tests++;
    if (rd_r !== 32'h2 || rd_a !== 32'h2) begin
      n_fail++; $display("FAIL setwin_edge got r=%h a=%h exp=2", rd_r, rd_a);
    end
    wr(2'd3, 32'h1f);
    address = 2'd3; #1;
    n_tests++;
    if (rd_r !== 32'h0) begin n_fail++; $display("FAIL setwin_clear got=%h exp=0", rd_r); end
  endtask

  task automatic test_mask();
    logic [31:0] exp [4];
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h1f);
    in_port = 5'b10011;
    repeat (9) @(negedge clk);
    address = 2'd3; #1;
    n_tests++;
    if (rd_r !== 32'h10 || irq_r !== 1'b0) begin
      n_fail++; $display("FAIL mask_gated got edge=%h irq=%b exp 10/0", rd_r, irq_r);
    end
    wr(2'd2, 32'hffff_fff0); #1;
    n_tests++;
    if (irq_r !== 1'b1) begin n_fail++; $display("FAIL mask_irq got=%b exp=1", irq_r); end
    wr(2'd1, 32'hffff_ffff);
    wr(2'd0, 32'h0);
    exp[0] = 32'h13; exp[1] = 32'h0; exp[2] = 32'h10; exp[3] = 32'h10;
    for (int k = 0; k < 4; k++) begin
      address = 2'(k); #1;
      n_tests++;
      if (rd_r !== exp[k]) begin n_fail++; $display("FAIL ro_write addr=%0d got=%h exp=%h", k, rd_r, exp[k]); end
    end
  endtask

  task automatic test_edge_types();
    wr(2'd3, 32'h1f);
    in_port = 5'b11011;
    repeat (9) @(negedge clk);
    address = 2'd3; #1;
    n_tests++;
    if (rd_r !== 32'h8 || rd_a !== 32'h8 || rd_f !== 32'h0) begin
      n_fail++; $display("FAIL type_rise got r=%h a=%h f=%h exp 8/8/0", rd_r, rd_a, rd_f);
    end
    wr(2'd3, 32'h8);
    in_port = 5'b10011;
    repeat (9) @(negedge clk);
    address = 2'd3; #1;
    n_tests++;
    if (rd_r !== 32'h0 || rd_a !== 32'h8 || rd_f !== 32'h8) begin
      n_fail++; $display("FAIL type_fall got r=%h a=%h f=%h exp 0/8/8", rd_r, rd_a, rd_f);
    end
  endtask

  task automatic test_random();
    logic [31:0] er, ea, ef;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      reset_n    = ($urandom_range(0, 199) != 0);
      chipselect = 1'b0;
      write_n    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1'b1;
        writedata  = $urandom;
      end
      #1;
      er = exp_rd(address, m_edge_r);
      ea = exp_rd(address, m_edge_a);
      ef = exp_rd(address, m_edge_f);
      n_tests++;
      if (rd_r !== er || rd_a !== ea || rd_f !== ef) begin
        n_fail++;
        $display("FAIL rand_read cyc=%0d addr=%0d got r=%h a=%h f=%h exp r=%h a=%h f=%h",
                 c, address, rd_r, rd_a, rd_f, er, ea, ef);
      end
      n_tests++;
      if (irq_r !== |(m_edge_r & m_mask) || irq_a !== |(m_edge_a & m_mask) ||
          irq_f !== |(m_edge_f & m_mask)) begin
        n_fail++;
        $display("FAIL rand_irq cyc=%0d got %b%b%b exp %b%b%b", c, irq_r, irq_a, irq_f,
                 |(m_edge_r & m_mask), |(m_edge_a & m_mask), |(m_edge_f & m_mask));
      end
    end
    @(negedge clk);
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0; in_port = '0;
    test_reset();
    test_rise_latency();
    test_glitch(3);
    test_glitch(4);
    test_set_wins();
    test_mask();
    test_edge_types();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
